// File: rtl/flash_arb_pkg.sv
// Shared state/owner encodings and default watchdog sizing for the flash port arbiter.
package flash_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_DM = 1'b0,
        OWN_IF = 1'b1
    } arb_owner_e;

    localparam int TO_CYCLES_DEF = 255;
    localparam int TO_W_DEF      = 8;

endpackage

// File: rtl/flash_arb_wdog.sv
// Access watchdog: counts enabled cycles since the last clear and pulses tc in the
// cycle that completes TO_CYCLES enabled cycles.
module flash_arb_wdog
    import flash_arb_pkg::*;
#(
    parameter int TO_W      = TO_W_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Count starts at 0 in the first enabled cycle, so the last one holds TO_CYCLES-1.
    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/flash_port_arbiter.sv
// Shares the flash_ss port between fetch (IF) and data (DM) with one access outstanding and
// a watchdog per access. Define FLASH_ARB_RR_EN for round-robin instead of DM-first priority.
module flash_port_arbiter
    import flash_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter int TO_W      = TO_W_DEF
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,

    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_err,

    output logic            flash_req,
    output logic            flash_we,
    output logic [AW-1:0]   flash_addr,
    output logic [DW-1:0]   flash_wdata,
    output logic [DW/8-1:0] flash_be,
    input  logic            flash_ack,
    input  logic [DW-1:0]   flash_rdata
);

    arb_state_e state, state_nxt;
    arb_owner_e owner;
    logic       dm_win, if_win, grant;
    logic       in_access, to_hit, done;
    logic [DW-1:0] rsp_data;

`ifdef FLASH_ARB_RR_EN
    arb_owner_e rr_prio;

    // rr_prio names the requester that wins the next contended grant.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rr_prio <= OWN_DM;
        end else if (dm_win) begin
            rr_prio <= OWN_IF;
        end else if (if_win) begin
            rr_prio <= OWN_DM;
        end
    end
`endif

    // Grants are combinational and suppressed while reset is held.
    always_comb begin
        dm_win = 1'b0;
        if_win = 1'b0;
        if (state == IDLE && !cpu_rst) begin
`ifdef FLASH_ARB_RR_EN
            if (dm_req && if_req) begin
                dm_win = (rr_prio == OWN_DM);
                if_win = (rr_prio == OWN_IF);
            end else begin
                dm_win = dm_req;
                if_win = if_req;
            end
`else
            dm_win = dm_req;
            if_win = if_req && !dm_req;
`endif
        end
    end

    assign grant     = dm_win | if_win;
    assign dm_gnt    = dm_win;
    assign if_gnt    = if_win;
    assign in_access = (state == ACCESS);
    assign flash_req = in_access;
    assign done      = in_access && (flash_ack || to_hit);

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  if (flash_ack || to_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    flash_arb_wdog #(
        .TO_W      (TO_W),
        .TO_CYCLES (TO_CYCLES)
    ) u_wdog (
        .clk_in (cpu_clk),
        .rst    (cpu_rst),
        .clr    (grant),
        .en     (in_access),
        .tc     (to_hit)
    );

    // Winner's request is frozen onto the flash bus for the whole access.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            owner       <= OWN_DM;
            flash_we    <= 1'b0;
            flash_addr  <= '0;
            flash_wdata <= '0;
            flash_be    <= '0;
        end else if (dm_win) begin
            owner       <= OWN_DM;
            flash_we    <= dm_we;
            flash_addr  <= dm_addr;
            flash_wdata <= dm_wdata;
            flash_be    <= dm_be;
        end else if (if_win) begin
            owner       <= OWN_IF;
            flash_we    <= 1'b0;
            flash_addr  <= if_addr;
            flash_wdata <= '0;
            flash_be    <= '1;
        end
    end

    // Stores and timeouts return zero data; an ack coinciding with timeout still counts as success.
    assign rsp_data = (flash_ack && !flash_we) ? flash_rdata : '0;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_err    <= 1'b0;
            if (done) begin
                if (owner == OWN_DM) begin
                    dm_rvalid <= 1'b1;
                    dm_rdata  <= rsp_data;
                    dm_err    <= !flash_ack;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= rsp_data;
                    if_err    <= !flash_ack;
                end
            end
        end
    end

endmodule
